// File: rtl/br_resolve_queue_pkg.sv
// Shared widths and the in-flight prediction record for the branch resolve queue.
// No logic here; latency and backpressure belong to the modules that import it.
package br_resolve_queue_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// Circular FIFO of in-flight predictions; head is readable in the same cycle, writes land next edge.
// Push while full and pop while empty are ignored; flush empties the queue by snapping head to tail.
module br_pred_fifo
    import br_resolve_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_dat,
    input  logic   pop,
    input  logic   flush,
    output logic   full,
    output logic   empty,
    output entry_t head_dat
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    entry_t              mem [DEPTH];
    logic                do_push;
    logic                do_pop;

    // Extra pointer MSB tells a wrapped-full queue apart from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
    end

endmodule

// File: rtl/br_resolve_queue.sv
// Tracks in-flight branch predictions, trains the predictor on resolve and flags mispredictions.
// Update/flush/counter outputs 1 cycle after resolve_i; push dropped when full or when a flush wins.
module br_resolve_queue
    import br_resolve_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [PC_W-1:0]  push_pc_i,
    input  logic             push_pred_i,
    input  logic             resolve_i,
    input  logic             resolve_taken_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic [PC_W-1:0]  upd_addr_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic             err_o
);

    entry_t push_dat;
    entry_t head_dat;
    logic   res_vld;
    logic   mispred;
    logic   fifo_push;

    assign push_dat.pc   = push_pc_i;
    assign push_dat.pred = push_pred_i;
    assign res_vld       = resolve_i && !empty_o;
    assign mispred       = res_vld && (resolve_taken_i != head_dat.pred);
    // A mispredict discards everything younger, including a branch fetched this same cycle.
    assign fifo_push     = push_i && !mispred;

    br_pred_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (res_vld),
        .flush    (mispred),
        .full     (full_o),
        .empty    (empty_o),
        .head_dat (head_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_o   <= 1'b0;
            upd_taken_o   <= 1'b0;
            upd_addr_o    <= '0;
            flush_o       <= 1'b0;
            mispred_cnt_o <= '0;
            err_o         <= 1'b0;
        end else begin
            upd_valid_o <= res_vld;
            flush_o     <= mispred;
            if (res_vld) begin
                upd_taken_o <= resolve_taken_i;
                upd_addr_o  <= head_dat.pc;
            end
            if (mispred)               mispred_cnt_o <= sat_inc(mispred_cnt_o);
            if (resolve_i && empty_o)  err_o         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue with hand-computed expectations.
module tb_br_resolve_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_i;
    logic [31:0] push_pc_i;
    logic        push_pred_i;
    logic        resolve_i;
    logic        resolve_taken_i;
    logic        full_o;
    logic        empty_o;
    logic        upd_valid_o;
    logic        upd_taken_o;
    logic [31:0] upd_addr_o;
    logic        flush_o;
    logic [15:0] mispred_cnt_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    br_resolve_queue #(.DEPTH_LOG2(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .push_i          (push_i),
        .push_pc_i       (push_pc_i),
        .push_pred_i     (push_pred_i),
        .resolve_i       (resolve_i),
        .resolve_taken_i (resolve_taken_i),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .upd_valid_o     (upd_valid_o),
        .upd_taken_o     (upd_taken_o),
        .upd_addr_o      (upd_addr_o),
        .flush_o         (flush_o),
        .mispred_cnt_o   (mispred_cnt_o),
        .err_o           (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic [31:0] pc, input logic pred,
                       input logic r, input logic t);
        push_i          = p;
        push_pc_i       = pc;
        push_pred_i     = pred;
        resolve_i       = r;
        resolve_taken_i = t;
        @(posedge clk);
        #1;
        push_i    = 1'b0;
        resolve_i = 1'b0;
    endtask

    task automatic check_upd(input string tag, input logic [31:0] addr, input logic taken);
        check({tag, "_vld"},   32'(upd_valid_o), 32'd1);
        check({tag, "_addr"},  upd_addr_o,       addr);
        check({tag, "_taken"}, 32'(upd_taken_o), 32'(taken));
    endtask

    initial begin
        rst_n = 1'b0; push_i = 1'b0; push_pc_i = '0; push_pred_i = 1'b0;
        resolve_i = 1'b0; resolve_taken_i = 1'b0;
        #1;
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full",  32'(full_o),  32'd0);
        check("rst_upd",   32'(upd_valid_o), 32'd0);
        check("rst_addr",  upd_addr_o, 32'd0);
        check("rst_taken", 32'(upd_taken_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_cnt",   32'(mispred_cnt_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two correct predictions train the predictor without flushing
        cyc(1, 32'h100, 1, 0, 0);
        cyc(1, 32'h104, 0, 0, 0);
        check("two_not_empty", 32'(empty_o), 32'd0);
        cyc(0, 0, 0, 1, 1);
        check_upd("ok0", 32'h100, 1);
        check("ok0_flush", 32'(flush_o), 32'd0);
        cyc(0, 0, 0, 1, 0);
        check_upd("ok1", 32'h104, 0);
        check("ok1_flush", 32'(flush_o), 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("idle_vld",   32'(upd_valid_o), 32'd0);
        check("idle_hold",  upd_addr_o, 32'h104);
        check("ok_empty",   32'(empty_o), 32'd1);
        check("ok_cnt",     32'(mispred_cnt_o), 32'd0);

        // Mispredict at head discards the younger entries
        cyc(1, 32'h200, 1, 0, 0);
        cyc(1, 32'h204, 0, 0, 0);
        cyc(1, 32'h208, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check_upd("mp", 32'h200, 0);
        check("mp_flush", 32'(flush_o), 32'd1);
        check("mp_cnt",   32'(mispred_cnt_o), 32'd1);
        check("mp_empty", 32'(empty_o), 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("mp_flush_1cyc", 32'(flush_o), 32'd0);
        check("mp_vld_1cyc",   32'(upd_valid_o), 32'd0);

        // Fill across the pointer wrap; extra pushes are dropped
        for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(4 * i), 1, 0, 0);
        check("fill_full", 32'(full_o), 32'd1);
        cyc(1, 32'h310, 1, 0, 0);
        check("drop5_full", 32'(full_o), 32'd1);
        cyc(1, 32'h314, 1, 1, 1);
        check_upd("wrap0", 32'h300, 1);
        check("fullpop_notfull", 32'(full_o), 32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 1, 1);
            check_upd("wrap", 32'h300 + 32'(4 * i), 1);
        end
        check("wrap_empty", 32'(empty_o), 32'd1);

        // Push alongside a correct resolve keeps occupancy
        cyc(1, 32'h400, 1, 0, 0);
        cyc(1, 32'h404, 1, 1, 1);
        check_upd("cc0", 32'h400, 1);
        check("cc_not_empty", 32'(empty_o), 32'd0);
        cyc(0, 0, 0, 1, 1);
        check_upd("cc1", 32'h404, 1);
        check("cc_empty", 32'(empty_o), 32'd1);

        // Push alongside a mispredict is dropped
        cyc(1, 32'h500, 1, 0, 0);
        cyc(1, 32'h504, 1, 1, 0);
        check("pm_flush", 32'(flush_o), 32'd1);
        check("pm_empty", 32'(empty_o), 32'd1);
        check("pm_cnt",   32'(mispred_cnt_o), 32'd2);

        // Resolve while empty: ignored, sticky error; a coincident push still lands
        cyc(0, 0, 0, 1, 1);
        check("emp_vld", 32'(upd_valid_o), 32'd0);
        check("emp_err", 32'(err_o), 32'd1);
        cyc(1, 32'h600, 1, 1, 0);
        check("emp_push_vld",   32'(upd_valid_o), 32'd0);
        check("emp_push_flush", 32'(flush_o), 32'd0);
        check("emp_push_ne",    32'(empty_o), 32'd0);
        cyc(0, 0, 0, 1, 1);
        check_upd("emp_drain", 32'h600, 1);
        check("err_sticky", 32'(err_o), 32'd1);

        // Counter saturation: preload near the top, then keep mispredicting
        force dut.mispred_cnt_o = 16'hFFFC;
        #1;
        release dut.mispred_cnt_o;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h700 + 32'(i), 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
            check("sat_cnt", 32'(mispred_cnt_o), (i < 3) ? 32'hFFFD + 32'(i) : 32'hFFFF);
        end

        // Reset mid-stream clears everything at once with no trailing pulses
        cyc(1, 32'h800, 1, 0, 0);
        cyc(1, 32'h804, 0, 0, 0);
        resolve_i = 1'b1; resolve_taken_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty_o), 32'd1);
        check("mid_rst_cnt",   32'(mispred_cnt_o), 32'd0);
        check("mid_rst_err",   32'(err_o), 32'd0);
        check("mid_rst_addr",  upd_addr_o, 32'd0);
        check("mid_rst_vld",   32'(upd_valid_o), 32'd0);
        resolve_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("post_rst_flush", 32'(flush_o), 32'd0);
        check("post_rst_vld",   32'(upd_valid_o), 32'd0);
        check("post_rst_empty", 32'(empty_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/br_resolve_queue.md
BR_RESOLVE_QUEUE -- requirements
Module: br_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2: queue holds 2**DEPTH_LOG2 in-flight predictions.
REQ-002 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have push_i  input  1  fetch stage issued a branch with a prediction.
REQ-005 SHALL have push_pc_i  input  32  PC of that branch.
REQ-006 SHALL have push_pred_i  input  1  predictor output for that branch (1 = taken).
REQ-007 SHALL have resolve_i  input  1  execute stage resolved the oldest in-flight branch.
REQ-008 SHALL have resolve_taken_i  input  1  actual outcome (1 = taken).
REQ-009 SHALL have full_o  output  1  queue full; push ignored.
REQ-010 SHALL have empty_o  output  1  queue empty.
REQ-011 SHALL have upd_valid_o  output  1  predictor-update strobe (drives the predictor update-enable).
REQ-012 SHALL have upd_taken_o  output  1  actual outcome to train with.
REQ-013 SHALL have upd_addr_o  output  32  PC to train (predictor write address).
REQ-014 SHALL have flush_o  output  1  misprediction; pipeline flush and redirect.
REQ-015 SHALL have mispred_cnt_o  output  16  saturating misprediction count.
REQ-016 SHALL have err_o  output  1  sticky: resolve received while empty.

Function
REQ-017 Queue SHALL be a circular FIFO of {pc, pred}; write/read pointers DEPTH_LOG2+1 bits wide, wrap modulo depth; extra MSB distinguishes full from empty.
REQ-018 push_i with full_o=0 SHALL write entry at tail, advance tail next edge; push while full SHALL be dropped, no state change.
REQ-019 resolve_i with empty_o=0 SHALL pop head; comparison uses head entry as seen in the same cycle.
REQ-020 On valid resolve, next cycle: upd_valid_o=1 for exactly one cycle, upd_addr_o=head pc, upd_taken_o=resolve_taken_i (training on every resolved branch).
REQ-021 If resolve_taken_i != head pred, next cycle flush_o=1 for exactly one cycle and mispred_cnt_o increments, holding at 0xFFFF.
REQ-022 On misprediction, all entries younger than the head SHALL be discarded: head and tail pointers equalized, queue empty next cycle.
REQ-023 Push coincident with a mispredicting resolve SHALL be dropped (flush wins); push coincident with a correct resolve SHALL be accepted, occupancy unchanged.
REQ-024 Push and resolve in same cycle while full SHALL: pop accepted, push dropped (full_o evaluated on current state).
REQ-025 Push and resolve while empty SHALL: push accepted, resolve ignored, err_o set.
REQ-026 full_o and empty_o SHALL be combinational from current pointers; all update/flush/counter outputs registered (latency 1 cycle from resolve_i).
REQ-027 Without valid resolve, upd_valid_o and flush_o SHALL be 0; upd_addr_o and upd_taken_o hold last value.

Reset
REQ-028 rst_n low SHALL asynchronously clear pointers (empty_o=1, full_o=0), upd_valid_o=0, upd_taken_o=0, upd_addr_o=0, flush_o=0, mispred_cnt_o=0, err_o=0.
REQ-029 Entry storage SHALL NOT require reset; entries are never read while invalid.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries with no further update or flush pulse.

Structure
REQ-031 Shared package SHALL hold the PC width (32), the counter width (16) and the entry record type {pc, pred}.
REQ-032 The FIFO storage and pointers SHALL be a sub-module br_pred_fifo; compare, update and counter logic in the top.

Verification
REQ-033 Push PCs 0x100(T),0x104(N); resolve T then N -> two upd_valid_o pulses, addr 0x100/0x104, flush_o never 1, count 0.
REQ-034 Push 0x200(T),0x204,0x208; resolve N -> flush_o=1 one cycle, count 1, empty_o=1 next cycle, upd_addr_o=0x200.
REQ-035 Fill 4 entries, 5th push -> full_o=1, 5th dropped; four resolves return PCs in push order across pointer wrap.
REQ-036 Resolve while empty -> no upd_valid_o, err_o=1 held until reset.
REQ-037 Force 65536 mispredictions -> mispred_cnt_o=0xFFFF and holds; assert rst_n low mid-stream -> all outputs zero immediately.
